// File: rtl/rename_map_table_ckpt_if.sv
// Rename-stage port bundle: rename lanes, commit lanes, checkpoint control.
// Carries only wires; all timing is owned by the map table.
// Master drives requests, slave returns mappings and checkpoint status.
interface rename_map_table_ckpt_if #(
    parameter int RN_WIDTH = 2,
    parameter int CREG_NUM = 32,
    parameter int PREG_NUM = 64,
    parameter int CKPT_NUM = 4,
    parameter int CM_WIDTH = 2
);
    localparam int CRW = $clog2(CREG_NUM);
    localparam int PW  = $clog2(PREG_NUM);
    localparam int CW  = $clog2(CKPT_NUM);

    logic [RN_WIDTH-1:0][CRW-1:0] rn_src1;
    logic [RN_WIDTH-1:0][CRW-1:0] rn_src2;
    logic [RN_WIDTH-1:0][PW:0]    rn_psrc1;
    logic [RN_WIDTH-1:0][PW:0]    rn_psrc2;
    logic [RN_WIDTH-1:0]          rn_wvalid;
    logic [RN_WIDTH-1:0][CRW-1:0] rn_dst;
    logic [RN_WIDTH-1:0][PW-1:0]  rn_pdst;
    logic [RN_WIDTH-1:0][PW:0]    rn_pold;

    logic [CM_WIDTH-1:0]          cm_valid;
    logic [CM_WIDTH-1:0][CRW-1:0] cm_creg;
    logic [CM_WIDTH-1:0][PW-1:0]  cm_preg;

    logic                         ckpt_take;
    logic [CW-1:0]                ckpt_id;
    logic                         ckpt_release;
    logic                         restore_valid;
    logic [CW-1:0]                restore_id;
    logic                         flush;
    logic                         ckpt_full;
    logic [CW:0]                  ckpt_count;
    logic                         ckpt_overflow;

    modport master (
        output rn_src1, rn_src2, rn_wvalid, rn_dst, rn_pdst,
        output cm_valid, cm_creg, cm_preg,
        output ckpt_take, ckpt_release, restore_valid, restore_id, flush,
        input  rn_psrc1, rn_psrc2, rn_pold,
        input  ckpt_id, ckpt_full, ckpt_count, ckpt_overflow
    );

    modport slave (
        input  rn_src1, rn_src2, rn_wvalid, rn_dst, rn_pdst,
        input  cm_valid, cm_creg, cm_preg,
        input  ckpt_take, ckpt_release, restore_valid, restore_id, flush,
        output rn_psrc1, rn_psrc2, rn_pold,
        output ckpt_id, ckpt_full, ckpt_count, ckpt_overflow
    );
endinterface

// File: rtl/rename_map_table_ckpt.sv
// Register alias table (speculative + committed maps) with in-order branch checkpoints.
// Source/old-dest lookups are combinational; map, checkpoint and status updates land at the next edge.
// No stall path: a take that finds every slot busy is dropped and raises a sticky overflow flag.
module rename_map_table_ckpt #(
    parameter int RN_WIDTH = 2,
    parameter int CREG_NUM = 32,
    parameter int PREG_NUM = 64,
    parameter int CKPT_NUM = 4,
    parameter int CM_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    rename_map_table_ckpt_if.slave  bus
);
    localparam int CRW = $clog2(CREG_NUM);
    localparam int PW  = $clog2(PREG_NUM);
    localparam int CW  = $clog2(CKPT_NUM);
    localparam int EW  = PW + 1;
    localparam logic [CW:0] FULL_CNT = (CW+1)'(CKPT_NUM);

    typedef logic [EW-1:0] ent_t;

    ent_t srat_q [CREG_NUM];
    ent_t srat_d [CREG_NUM];
    ent_t arat_q [CREG_NUM];
    ent_t arat_d [CREG_NUM];
    ent_t srat_ren [CREG_NUM];
    ent_t snap_q [CKPT_NUM][CREG_NUM];

    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] tail_q, tail_d;
    logic [CW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          take_ok;
    logic          rel_ok;
    logic          snap_we;
    logic [CW-1:0] rst_dist;
    logic          rst_live;

    logic [RN_WIDTH-1:0][PW:0] psrc1_c;
    logic [RN_WIDTH-1:0][PW:0] psrc2_c;
    logic [RN_WIDTH-1:0][PW:0] pold_c;

    // Lookups: SRAT value, overridden by the youngest older lane writing the same creg; creg 0 reads zero.
    always_comb begin
        for (int i = 0; i < RN_WIDTH; i++) begin
            psrc1_c[i] = srat_q[bus.rn_src1[i]];
            psrc2_c[i] = srat_q[bus.rn_src2[i]];
            pold_c[i]  = srat_q[bus.rn_dst[i]];
            for (int j = 0; j < RN_WIDTH; j++) begin
                if (j < i && bus.rn_wvalid[j]) begin
                    if (bus.rn_dst[j] == bus.rn_src1[i]) psrc1_c[i] = {1'b1, bus.rn_pdst[j]};
                    if (bus.rn_dst[j] == bus.rn_src2[i]) psrc2_c[i] = {1'b1, bus.rn_pdst[j]};
                    if (bus.rn_dst[j] == bus.rn_dst[i])  pold_c[i]  = {1'b1, bus.rn_pdst[j]};
                end
            end
            if (bus.rn_src1[i] == '0) psrc1_c[i] = '0;
            if (bus.rn_src2[i] == '0) psrc2_c[i] = '0;
            if (bus.rn_dst[i] == '0)  pold_c[i]  = '0;
        end
    end

    assign bus.rn_psrc1 = psrc1_c;
    assign bus.rn_psrc2 = psrc2_c;
    assign bus.rn_pold  = pold_c;

    // Restore target is live when its distance from head falls inside the occupied window.
    assign rst_dist = bus.restore_id - head_q;
    assign rst_live = ({1'b0, rst_dist} < count_q);

    // Next-state for both maps and the checkpoint ring: flush beats restore beats normal rename.
    always_comb begin
        for (int c = 0; c < CREG_NUM; c++) begin
            arat_d[c]   = arat_q[c];
            srat_ren[c] = srat_q[c];
            srat_d[c]   = srat_q[c];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        snap_we = 1'b0;

        // Commits, later lanes override earlier ones.
        for (int k = 0; k < CM_WIDTH; k++) begin
            if (bus.cm_valid[k] && bus.cm_creg[k] != '0) begin
                arat_d[bus.cm_creg[k]] = {1'b1, bus.cm_preg[k]};
            end
        end

        // Rename writes, later lanes override earlier ones; this is also the snapshot payload.
        for (int i = 0; i < RN_WIDTH; i++) begin
            if (bus.rn_wvalid[i] && bus.rn_dst[i] != '0) begin
                srat_ren[bus.rn_dst[i]] = {1'b1, bus.rn_pdst[i]};
            end
        end

        take_ok = bus.ckpt_take && (count_q != FULL_CNT || bus.ckpt_release);
        rel_ok  = bus.ckpt_release && (count_q != '0);

        if (bus.flush) begin
            for (int c = 0; c < CREG_NUM; c++) srat_d[c] = arat_d[c];
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (bus.restore_valid && rst_live) begin
            for (int c = 0; c < CREG_NUM; c++) srat_d[c] = snap_q[bus.restore_id][c];
            tail_d = bus.restore_id + 1'b1;
            if (rel_ok) begin
                // Release applies after truncation: drop the oldest of the surviving window.
                head_d  = head_q + 1'b1;
                count_d = {1'b0, rst_dist};
            end else begin
                count_d = {1'b0, rst_dist} + 1'b1;
            end
        end else begin
            for (int c = 0; c < CREG_NUM; c++) srat_d[c] = srat_ren[c];
            if (take_ok) begin
                snap_we = 1'b1;
                tail_d  = tail_q + 1'b1;
            end else if (bus.ckpt_take) begin
                ovf_d = 1'b1;
            end
            if (rel_ok) head_d = head_q + 1'b1;
            count_d = count_q + {{CW{1'b0}}, take_ok} - {{CW{1'b0}}, rel_ok};
        end
    end

    // Map and ring state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CREG_NUM; c++) begin
                srat_q[c] <= '0;
                arat_q[c] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int c = 0; c < CREG_NUM; c++) begin
                srat_q[c] <= srat_d[c];
                arat_q[c] <= arat_d[c];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Snapshot storage: contents are only read for live slots, so no reset is needed.
    always_ff @(posedge clk) begin
        if (snap_we) begin
            for (int c = 0; c < CREG_NUM; c++) snap_q[tail_q][c] <= srat_ren[c];
        end
    end

    assign bus.ckpt_id       = tail_q;
    assign bus.ckpt_full     = (count_q == FULL_CNT);
    assign bus.ckpt_count    = count_q;
    assign bus.ckpt_overflow = ovf_q;
endmodule

// File: tb/tb_rename_map_table_ckpt.sv
module tb_rename_map_table_ckpt;
    localparam int NCK = 4;
    localparam int NCR = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rename_map_table_ckpt_if bus ();
    rename_map_table_ckpt dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: entries encoded as 0 (arch file) or 64+preg (mapped).
    int m_srat [NCR];
    int m_arat [NCR];
    int m_snap [NCK][NCR];
    int m_live [$];
    int m_tail;
    bit m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCR; c++) begin
            m_srat[c] = 0;
            m_arat[c] = 0;
        end
        m_live.delete();
        m_tail = 0;
        m_ovf  = 1'b0;
    endtask

    // Applied at each posedge with the inputs that were present during that cycle.
    task automatic model_step();
        int new_arat [NCR];
        int ren [NCR];
        int pos;
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCR; c++) begin
            new_arat[c] = m_arat[c];
            ren[c] = m_srat[c];
        end
        for (int k = 0; k < 2; k++)
            if (bus.cm_valid[k] && bus.cm_creg[k] != 0) new_arat[bus.cm_creg[k]] = 64 + int'(bus.cm_preg[k]);
        for (int i = 0; i < 2; i++)
            if (bus.rn_wvalid[i] && bus.rn_dst[i] != 0) ren[bus.rn_dst[i]] = 64 + int'(bus.rn_pdst[i]);
        pos = -1;
        foreach (m_live[q]) if (m_live[q] == int'(bus.restore_id)) pos = q;
        if (bus.flush) begin
            for (int c = 0; c < NCR; c++) m_srat[c] = new_arat[c];
            m_live.delete();
            m_tail = 0;
        end else if (bus.restore_valid && pos >= 0) begin
            for (int c = 0; c < NCR; c++) m_srat[c] = m_snap[bus.restore_id][c];
            while (m_live.size() > pos + 1) void'(m_live.pop_back());
            m_tail = (int'(bus.restore_id) + 1) % NCK;
            if (bus.ckpt_release) void'(m_live.pop_front());
        end else begin
            if (bus.ckpt_release && m_live.size() > 0) void'(m_live.pop_front());
            if (bus.ckpt_take) begin
                if (m_live.size() < NCK) begin
                    for (int c = 0; c < NCR; c++) m_snap[m_tail][c] = ren[c];
                    m_live.push_back(m_tail);
                    m_tail = (m_tail + 1) % NCK;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            for (int c = 0; c < NCR; c++) m_srat[c] = ren[c];
        end
        for (int c = 0; c < NCR; c++) m_arat[c] = new_arat[c];
    endtask

    function automatic int exp_rd(input int lane, input int src);
        int r;
        if (src == 0) return 0;
        r = m_srat[src];
        for (int j = 0; j < lane; j++)
            if (bus.rn_wvalid[j] && int'(bus.rn_dst[j]) == src) r = 64 + int'(bus.rn_pdst[j]);
        return r;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("psrc1[%0d]", i), int'(bus.rn_psrc1[i]), exp_rd(i, int'(bus.rn_src1[i])));
                chk($sformatf("psrc2[%0d]", i), int'(bus.rn_psrc2[i]), exp_rd(i, int'(bus.rn_src2[i])));
                chk($sformatf("pold[%0d]", i),  int'(bus.rn_pold[i]),  exp_rd(i, int'(bus.rn_dst[i])));
            end
            chk("ckpt_id",       int'(bus.ckpt_id),       m_tail);
            chk("ckpt_count",    int'(bus.ckpt_count),    m_live.size());
            chk("ckpt_full",     int'(bus.ckpt_full),     int'(m_live.size() == NCK));
            chk("ckpt_overflow", int'(bus.ckpt_overflow), int'(m_ovf));
        end
    end

    task automatic idle();
        bus.rn_src1 = '0; bus.rn_src2 = '0; bus.rn_wvalid = '0;
        bus.rn_dst = '0;  bus.rn_pdst = '0;
        bus.cm_valid = '0; bus.cm_creg = '0; bus.cm_preg = '0;
        bus.ckpt_take = 1'b0; bus.ckpt_release = 1'b0;
        bus.restore_valid = 1'b0; bus.restore_id = '0; bus.flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        idle();
    endtask

    task automatic ren(input int lane, input int dst, input int pdst);
        bus.rn_wvalid[lane] = 1'b1;
        bus.rn_dst[lane]    = 5'(dst);
        bus.rn_pdst[lane]   = 6'(pdst);
    endtask

    task automatic take_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ckpt_take = 1'b1;
            tick();
        end
    endtask

    initial begin
        idle();
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_count", int'(bus.ckpt_count), 0);

        // Intra-group bypass on source and old-destination.
        ren(0, 5, 40);
        ren(1, 5, 41);
        bus.rn_src1[1] = 5'd5;
        #1;
        chk("byp_psrc1_l1", int'(bus.rn_psrc1[1]), 104);
        chk("byp_pold_l1",  int'(bus.rn_pold[1]),  104);
        chk("byp_pold_l0",  int'(bus.rn_pold[0]),  0);
        tick();
        bus.rn_src1[0] = 5'd5;
        ren(0, 0, 9);
        bus.rn_src1[1] = 5'd0;
        #1;
        chk("x5_after", int'(bus.rn_psrc1[0]), 105);
        chk("x0_bypass", int'(bus.rn_psrc1[1]), 0);
        tick();
        bus.rn_src2[0] = 5'd0;
        bus.rn_src1[0] = 5'd5;
        tick();

        // Snapshot captures the same-cycle lane-1 write; restore brings it back.
        ren(0, 3, 10);
        tick();
        ren(1, 3, 11);
        bus.ckpt_take = 1'b1;
        #1;
        chk("take_id0", int'(bus.ckpt_id), 0);
        tick();
        ren(0, 3, 12);
        tick();
        bus.rn_src1[0] = 5'd3;
        #1;
        chk("x3_p12", int'(bus.rn_psrc1[0]), 76);
        bus.restore_valid = 1'b1;
        bus.restore_id = 2'd0;
        ren(1, 3, 13);
        tick();
        bus.rn_src1[0] = 5'd3;
        #1;
        chk("restore_x3", int'(bus.rn_psrc1[0]), 75);
        chk("restore_cnt", int'(bus.ckpt_count), 1);
        chk("restore_tail", int'(bus.ckpt_id), 1);

        // Fill the ring, overflow, then take+release while full.
        take_n(3);
        #1;
        chk("full_flag", int'(bus.ckpt_full), 1);
        bus.ckpt_take = 1'b1;
        tick();
        #1;
        chk("ovf_set", int'(bus.ckpt_overflow), 1);
        chk("ovf_cnt", int'(bus.ckpt_count), 4);
        bus.ckpt_take = 1'b1;
        bus.ckpt_release = 1'b1;
        tick();
        #1;
        chk("tr_cnt", int'(bus.ckpt_count), 4);
        chk("tr_id", int'(bus.ckpt_id), 1);

        // Flush copies the committed map including this cycle's commit.
        ren(0, 7, 33);
        tick();
        bus.rn_src1[0] = 5'd7;
        #1;
        chk("x7_p33", int'(bus.rn_psrc1[0]), 97);
        bus.cm_valid[0] = 1'b1;
        bus.cm_creg[0] = 5'd7;
        bus.cm_preg[0] = 6'd20;
        bus.flush = 1'b1;
        tick();
        bus.rn_src1[0] = 5'd7;
        bus.rn_src2[0] = 5'd3;
        #1;
        chk("flush_x7", int'(bus.rn_psrc1[0]), 84);
        chk("flush_x3", int'(bus.rn_psrc2[0]), 0);
        chk("flush_cnt", int'(bus.ckpt_count), 0);

        // Build head=2 with live slots 2,3,0, then restore slot 3 with release.
        take_n(2);
        bus.ckpt_release = 1'b1;
        tick();
        bus.ckpt_release = 1'b1;
        tick();
        take_n(1);
        ren(0, 9, 50);
        bus.ckpt_take = 1'b1;
        tick();
        ren(0, 9, 51);
        bus.ckpt_take = 1'b1;
        tick();
        bus.restore_valid = 1'b1;
        bus.restore_id = 2'd3;
        bus.ckpt_release = 1'b1;
        tick();
        bus.rn_src1[0] = 5'd9;
        bus.rn_src1[1] = 5'd7;
        #1;
        chk("r3_cnt", int'(bus.ckpt_count), 1);
        chk("r3_tail", int'(bus.ckpt_id), 0);
        chk("r3_x9", int'(bus.rn_psrc1[0]), 114);
        chk("r3_x7", int'(bus.rn_psrc1[1]), 84);
        bus.restore_valid = 1'b1;
        bus.restore_id = 2'd1;
        tick();
        bus.rn_src1[0] = 5'd9;
        #1;
        chk("r1_ign_cnt", int'(bus.ckpt_count), 1);
        chk("r1_ign_x9", int'(bus.rn_psrc1[0]), 114);

        // Reset in the middle of activity.
        ren(0, 10, 1);
        bus.ckpt_take = 1'b1;
        tick();
        take_n(1);
        #1;
        chk("pre_rst_cnt", int'(bus.ckpt_count), 3);
        reset = 1'b1;
        model_reset();
        bus.rn_src1[0] = 5'd9;
        bus.rn_src1[1] = 5'd10;
        #1;
        chk("mid_rst_cnt", int'(bus.ckpt_count), 0);
        chk("mid_rst_full", int'(bus.ckpt_full), 0);
        chk("mid_rst_x9", int'(bus.rn_psrc1[0]), 0);
        tick();
        reset = 1'b0;
        tick();
        bus.rn_src1[1] = 5'd10;
        #1;
        chk("post_rst_x10", int'(bus.rn_psrc1[1]), 0);
        chk("post_rst_ovf", int'(bus.ckpt_overflow), 0);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rename_map_table_ckpt.md
Name: rename_map_table_ckpt

Overview:
- Parametrised multi-lane register alias table for the rename stage.
- Keeps a speculative map (SRAT) and a committed map (ARAT) of {valid, preg id} per architectural register. valid=0 means the value lives in the architectural register file.
- Adds branch checkpoints: up to CKPT_NUM SRAT snapshots, allocated and released in order, with single-cycle restore on mispredict.
- Sits between decode and ROB/issue.

Parameters:
- RN_WIDTH, 2, rename lanes per cycle
- CREG_NUM, 32, architectural registers; creg 0 is hard-wired zero
- PREG_NUM, 64, physical registers; preg id width = clog2(PREG_NUM)
- CKPT_NUM, 4, checkpoint slots (power of 2); id width CW = clog2(CKPT_NUM)
- CM_WIDTH, 2, commit lanes per cycle

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rn_src1[i], rn_src2[i]  in  RN_WIDTH x clog2(CREG_NUM)  source cregs per lane
- rn_psrc1[i], rn_psrc2[i]  out  RN_WIDTH x (1+PW)  {valid, id} source mappings, combinational
- rn_wvalid[i]  in  RN_WIDTH x 1  lane i writes a new mapping
- rn_dst[i]  in  RN_WIDTH x clog2(CREG_NUM)  destination creg
- rn_pdst[i]  in  RN_WIDTH x PW  newly allocated preg
- rn_pold[i]  out  RN_WIDTH x (1+PW)  previous mapping of rn_dst[i], for ROB free-on-commit
- cm_valid[k], cm_creg[k], cm_preg[k]  in  CM_WIDTH lanes  committed mappings, oldest lane first
- ckpt_take  in  1  snapshot after this cycle's rename writes
- ckpt_id  out  CW  slot allocated when ckpt_take is accepted (= tail)
- ckpt_release  in  1  free oldest checkpoint (branch resolved correct)
- restore_valid  in  1  mispredict restore
- restore_id  in  CW  checkpoint to restore
- flush  in  1  full flush: SRAT <= ARAT
- ckpt_full  out  1  count == CKPT_NUM
- ckpt_count  out  CW+1  live checkpoints
- ckpt_overflow  out  1  sticky error flag

Behaviour:
- Reset (async): all SRAT/ARAT entries {0,0}; head=tail=count=0; ckpt_overflow=0. Snapshot contents are don't-care.
- Source read, combinational, zero latency:
  - base value = SRAT[src].
  - Intra-group bypass: if a lane j<i has rn_wvalid[j] and rn_dst[j]==src, the result is {1, rn_pdst[j]} from the highest such j.
  - src==0 always returns {0,0}.
- rn_pold[i] uses the same bypass rule, applied to rn_dst[i] against lanes j<i.
- Rename write at the posedge: SRAT[rn_dst[i]] <= {1, rn_pdst[i]}. On a same-creg collision the highest lane wins. Writes to creg 0 are dropped.
- Commit at the posedge: ARAT[cm_creg[k]] <= {1, cm_preg[k]}, highest lane wins. Commit never modifies SRAT or snapshots.
- Checkpoint take:
  - Accepted when count<CKPT_NUM or ckpt_release is asserted in the same cycle.
  - Snapshot[tail] <= SRAT next-state, which includes this cycle's rename writes. Upstream must put the branch in the last valid lane.
  - tail++ modulo CKPT_NUM; ckpt_id = tail, presented combinationally.
  - If not accepted: ignored, and ckpt_overflow <= 1 (sticky until reset).
- Release: head++ and count--. Ignored when count==0.
- Restore:
  - Legal only when restore_id is live, i.e. (restore_id - head) mod CKPT_NUM < count. Otherwise the restore is ignored.
  - SRAT <= Snapshot[restore_id].
  - tail <= restore_id+1; count <= (restore_id - head) mod CKPT_NUM + 1. The restored checkpoint itself stays live; all younger ones are freed.
  - Same-cycle rename writes and ckpt_take are discarded.
  - A simultaneous release is still applied: head++ and count-- after truncation. If the released slot is restore_id, count becomes 0.
- Flush: SRAT <= ARAT next-state, which includes this cycle's commits. head=tail=count=0. Rename writes, take, release and restore are all discarded.
- Priority: reset > flush > restore > (rename writes, take, release). Commit is applied in every non-reset cycle.
- ckpt_full and ckpt_count are registered-state derived and update the cycle after the event.

Test Plan:
- Reset mid-operation with count=3 and SRAT populated -> next cycle all rn_psrc read {0,0}, ckpt_count=0, ckpt_full=0.
- Lane0 dst=x5 pdst=40, lane1 src1=x5 dst=x5 pdst=41, same cycle -> lane1 psrc1={1,40}, rn_pold[1]={1,40}; next cycle SRAT[x5]={1,41}. Also: dst=x0 -> SRAT[x0] stays {0,0}.
- x3->p10, then ckpt_take (id 0) in the same cycle as x3->p11 in lane1 -> snapshot0 holds x3=p11. Then x3->p12; restore_id=0 -> x3 reads {1,11}, count=1, tail=1.
- Take 4 checkpoints -> ckpt_full=1. A 5th take -> ignored, ckpt_overflow=1. Take together with release while full -> accepted, count stays 4, ckpt_overflow unchanged.
- Commit x7->p20 with flush in the same cycle while SRAT x7=p33 -> next cycle x7 reads {1,20}, count=0.
- head=2, count=3 (slots 2,3,0); restore_id=3 with release -> count=1, head=3, tail=0. restore_id=1 (not live) -> ignored.
